spike_stream_ram: RTL

Parametrised input-spike frame store with a built-in playback sequencer. Host or loader logic writes spike frames (one bit per input neuron) through an independent write port. On `start`, the block streams frames 0..num_frames-1 to the SNN core over a valid/ready interface, with an optional loop mode and abort. It sits between the input loader and the first neuron layer, and is the successor to the fixed 256x1002 single-port input spike RAM.

---
 rtl/snn_pkg.sv | 15 +
 rtl/spike_out_fifo.sv | 67 ++++++
 rtl/spike_stream_ram.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared SNN definitions: default array geometry and the playback sequencer states.
package snn_pkg;

  // Default frame width (input neurons) and frame store depth, shared with the neuron array.
  localparam int SNN_DATA_W = 256;
  localparam int SNN_DEPTH  = 1002;

  // Playback sequencer states.
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_STREAM = 2'd1,
    SEQ_DONE   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/spike_out_fifo.sv
// Two-entry output FIFO between the frame store and the SNN core.
// Head entry drives the consumer directly; flush empties it without touching storage.
module spike_out_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic [W-1:0] ent_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic [1:0]   count_nxt_s;
  logic         push_s;
  logic         pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_data  = ent_r[rd_ptr_r];
  assign occupancy = count_r;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Next occupancy from this cycle's push/pop combination.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and occupancy; flush discards contents but leaves data registers as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_r[0] <= {W{1'b0}};
      ent_r[1] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        ent_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/spike_stream_ram.sv
// Input-spike frame store with playback sequencer.
// The synchronous read of the frame store is captured directly into the output
// FIFO entry, so a read issued in cycle t is presented to the core in cycle t+1.
module spike_stream_ram
  import snn_pkg::*;
#(
  parameter int DATA_W = SNN_DATA_W,
  parameter int DEPTH  = SNN_DEPTH,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_frames,
  input  logic              loop_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_frame,
  output logic              busy,
  output logic              done,
  output logic              err_oob
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                FW      = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];

  seq_state_e        state_r;
  seq_state_e        state_nxt_s;
  logic [ADDR_W-1:0] n_r;
  logic [ADDR_W-1:0] n_nxt_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_nxt_s;
  logic              more_r;
  logic              more_nxt_s;
  logic              busy_r;
  logic              done_r;
  logic              err_oob_r;

  logic              wr_in_range_s;
  logic [ADDR_W-1:0] clamp_s;
  logic              issue_s;
  logic              last_s;
  logic              drain_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [FW-1:0]     fifo_in_s;
  logic [FW-1:0]     fifo_out_s;
  logic              fifo_in_ready_s;
  logic              fifo_out_valid_s;
  logic              fifo_pop_s;
  logic [1:0]        fifo_occ_s;

  assign wr_in_range_s = (wr_addr < DEPTH_A);
  assign clamp_s       = (num_frames > DEPTH_A) ? DEPTH_A : num_frames;
  assign last_s        = (ptr_r == (n_r - ONE_A));
  // fifo_in_ready_s means occupancy < 2; reads land in the FIFO on the issuing edge,
  // so there is never a second in-flight read to account for.
  assign issue_s       = (state_r == SEQ_STREAM) && more_r && fifo_in_ready_s && !abort;
  assign fifo_pop_s    = fifo_out_valid_s && out_ready;
  assign drain_s       = (fifo_occ_s == 2'd0) || ((fifo_occ_s == 2'd1) && fifo_pop_s);
  assign rd_word_s     = mem_r[ptr_r[IDX_W-1:0]];
  assign fifo_in_s     = {ptr_r, rd_word_s};

  // Frame store write port; out-of-range writes are dropped. Not reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range_s) begin
      mem_r[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Sticky out-of-range write flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob_r <= 1'b0;
    end else if (wr_en && !wr_in_range_s) begin
      err_oob_r <= 1'b1;
    end else begin
      err_oob_r <= err_oob_r;
    end
  end

  // Sequencer next-state: start/abort handling, pointer advance, wrap and drain.
  always_comb begin
    state_nxt_s = state_r;
    n_nxt_s     = n_r;
    ptr_nxt_s   = ptr_r;
    more_nxt_s  = more_r;
    case (state_r)
      SEQ_IDLE: begin
        if (abort) begin
          state_nxt_s = SEQ_IDLE;
        end else if (start) begin
          n_nxt_s   = clamp_s;
          ptr_nxt_s = ZERO_A;
          if (clamp_s == ZERO_A) begin
            state_nxt_s = SEQ_DONE;
            more_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = SEQ_STREAM;
            more_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = SEQ_IDLE;
        end
      end
      SEQ_STREAM: begin
        if (abort) begin
          state_nxt_s = SEQ_IDLE;
          more_nxt_s  = 1'b0;
        end else begin
          if (issue_s) begin
            if (last_s) begin
              ptr_nxt_s  = ZERO_A;
              more_nxt_s = loop_en;
            end else begin
              ptr_nxt_s = ptr_r + ONE_A;
            end
          end else begin
            ptr_nxt_s = ptr_r;
          end
          if (!more_r && drain_s) begin
            state_nxt_s = SEQ_DONE;
          end else begin
            state_nxt_s = SEQ_STREAM;
          end
        end
      end
      SEQ_DONE: begin
        state_nxt_s = SEQ_IDLE;
        more_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = SEQ_IDLE;
        more_nxt_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SEQ_IDLE;
      n_r     <= ZERO_A;
      ptr_r   <= ZERO_A;
      more_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      n_r     <= n_nxt_s;
      ptr_r   <= ptr_nxt_s;
      more_r  <= more_nxt_s;
      busy_r  <= (state_nxt_s != SEQ_IDLE);
      done_r  <= (state_nxt_s == SEQ_DONE);
    end
  end

  spike_out_fifo #(
    .W (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .in_valid  (issue_s),
    .in_ready  (fifo_in_ready_s),
    .in_data   (fifo_in_s),
    .out_valid (fifo_out_valid_s),
    .out_ready (out_ready),
    .out_data  (fifo_out_s),
    .occupancy (fifo_occ_s)
  );

  assign out_valid = fifo_out_valid_s;
  assign out_data  = fifo_out_s[DATA_W-1:0];
  assign out_frame = fifo_out_s[FW-1:DATA_W];
  assign busy      = busy_r;
  assign done      = done_r;
  assign err_oob   = err_oob_r;

endmodule
